pad_count_core: RTL
===================

PAD_COUNT_CORE -- requirements
Module: pad_count_core

Interface
REQ-001 Parameter: WIDTH, 41, counter and pad-bus width.
REQ-002 Parameter: SYNC_STAGES, 2, synchronizer depth on oeb, web and pad_in.
REQ-003 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-005 Port: oeb  input  1  pad output-enable strobe, active-low, asynchronous to clk.
REQ-006 Port: web  input  1  pad write-enable strobe, active-low, asynchronous to clk.
REQ-007 Port: pad_in  input  WIDTH  value driven onto the bidirectional count pads by the external host.
REQ-008 Port: pad_out  output  WIDTH  value driven onto the count pads when enabled.
REQ-009 Port: pad_oe  output  WIDTH  per-bit pad output enable, active-high, all bits always equal.
REQ-010 Port: count  output  WIDTH  live counter value.
REQ-011 Port: wrapped  output  1  sticky flag, set when the counter wraps.

Function
REQ-012 The block SHALL pass oeb, web and pad_in through SYNC_STAGES flops each; oeb_s, web_s and pad_in_s denote the synchronized values, and all decisions SHALL use only these.
REQ-013 FSM states: IDLE, LOAD, READ; encoding free, no unreachable-state lockup (illegal state -> IDLE).
REQ-014 IDLE -> LOAD when web_s==0; IDLE -> READ when web_s==1 and oeb_s==0; otherwise stay.
REQ-015 LOAD -> IDLE when web_s==1; web_s==0 in any state forces LOAD on the next edge (web has priority over oeb).
REQ-016 READ -> IDLE when oeb_s==1 and web_s==1; READ -> LOAD when web_s==0.
REQ-017 In LOAD, count SHALL take pad_in_s on every edge and SHALL NOT increment; the last value sampled before leaving LOAD is retained.
REQ-018 In IDLE and READ, count SHALL increment by 1 every cycle, modulo 2^WIDTH.
REQ-019 Wrap: count 2^WIDTH-1 -> 0 in IDLE/READ SHALL set wrapped on the same edge; wrapped stays set until reset or entry into LOAD, which clears it.
REQ-020 Entering READ SHALL capture count (pre-increment value on that edge) into a snapshot register; pad_out SHALL present the snapshot, constant for the whole READ residency, while count keeps running.
REQ-021 pad_oe SHALL be all-ones only while in READ, registered (asserted the cycle after the READ-entry edge, deasserted on the edge leaving READ); all-zeros in IDLE and LOAD.
REQ-022 pad_oe SHALL never be asserted in any cycle where state is LOAD (no contention with host-driven pads).
REQ-023 pad_out SHALL be 0 whenever pad_oe is 0.
REQ-024 Latency: pin edge on oeb/web to state change = SYNC_STAGES+1 clk edges; oeb falling to pad_oe high = SYNC_STAGES+2 edges.
REQ-025 Re-entering READ after leaving it SHALL capture a fresh snapshot.

Reset
REQ-026 While rst_n==0 on a rising edge: state=IDLE, count=0, wrapped=0, snapshot=0, pad_oe=0, pad_out=0, synchronizer flops oeb/web=1, pad_in=0.
REQ-027 Reset asserted mid-LOAD or mid-READ SHALL take effect on that edge and override all other updates; no partial load survives.
REQ-028 First increment SHALL occur on the first edge with rst_n==1 (count=1 after that edge), provided synchronized strobes are high.

Verification
REQ-029 Reset release, oeb=web=1 for 10 cycles -> count=10, wrapped=0, pad_oe=0, pad_out=0.
REQ-030 web=0 with pad_in=41'h1_0000_0000 for 6 cycles then web=1 -> count holds 41'h1_0000_0000 while in LOAD, pad_oe stays 0, increments to 41'h1_0000_0001 on first edge back in IDLE.
REQ-031 Load 41'h1FF_FFFF_FFFE, release web -> count goes ...FFFF then 0; wrapped=1 on the wrap edge and remains 1; subsequent load clears it.
REQ-032 From count=100, drop oeb for 20 cycles -> pad_oe rises SYNC_STAGES+2 edges later, pad_out frozen at snapshot value, count continues; raising oeb drops pad_oe and zeroes pad_out.
REQ-033 oeb=0 and web=0 simultaneously -> state LOAD, pad_oe never asserts, count tracks pad_in_s; releasing web with oeb still 0 -> READ with snapshot of loaded value.
REQ-034 Assert rst_n=0 for one cycle during READ at count=500 -> next cycle count=0, pad_oe=0, state IDLE, wrapped=0.

Source files
------------

// File: rtl/pad_count_core.sv
// ============================================================================
//  Module      : pad_count_core
//  Description : Free-running counter behind a bidirectional pad bus. The host
//                loads the counter through the pads while web is low and reads
//                back a frozen snapshot of it while oeb is low.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pad_count_core #(
  parameter int WIDTH       = 41,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             oeb,
  input  logic             web,
  input  logic [WIDTH-1:0] pad_in,
  output logic [WIDTH-1:0] pad_out,
  output logic [WIDTH-1:0] pad_oe,
  output logic [WIDTH-1:0] count,
  output logic             wrapped
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_READ = 2'd2
  } state_t;

  // Synchronizer chains; element [SYNC_STAGES-1] is the settled value.
  logic [SYNC_STAGES-1:0] oeb_sync_q, oeb_sync_d;
  logic [SYNC_STAGES-1:0] web_sync_q, web_sync_d;
  logic [WIDTH-1:0]       pad_sync_q [SYNC_STAGES];
  logic [WIDTH-1:0]       pad_sync_d [SYNC_STAGES];

  logic             oeb_s;
  logic             web_s;
  logic [WIDTH-1:0] pad_in_s;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             wrapped_q, wrapped_d;
  logic [WIDTH-1:0] snap_q, snap_d;
  logic             pad_oe_q, pad_oe_d;
  logic [WIDTH-1:0] pad_out_q, pad_out_d;

  assign oeb_s    = oeb_sync_q[SYNC_STAGES-1];
  assign web_s    = web_sync_q[SYNC_STAGES-1];
  assign pad_in_s = pad_sync_q[SYNC_STAGES-1];

  // Shift each asynchronous input one stage further down its chain.
  always_comb begin
    oeb_sync_d    = oeb_sync_q;
    web_sync_d    = web_sync_q;
    pad_sync_d    = pad_sync_q;
    oeb_sync_d[0] = oeb;
    web_sync_d[0] = web;
    pad_sync_d[0] = pad_in;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      oeb_sync_d[i] = oeb_sync_q[i-1];
      web_sync_d[i] = web_sync_q[i-1];
      pad_sync_d[i] = pad_sync_q[i-1];
    end
  end

  // Next-state logic: a low web forces LOAD from any state, ahead of oeb.
  always_comb begin
    state_d = ST_IDLE;
    if (!web_s) begin
      state_d = ST_LOAD;
    end else begin
      case (state_q)
        ST_IDLE: state_d = oeb_s ? ST_IDLE : ST_READ;
        ST_LOAD: state_d = ST_IDLE;
        ST_READ: state_d = oeb_s ? ST_IDLE : ST_READ;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Counter, wrap flag, snapshot and registered pad drive.
  always_comb begin
    count_d   = count_q;
    wrapped_d = wrapped_q;
    snap_d    = snap_q;
    pad_oe_d  = 1'b0;
    pad_out_d = '0;

    // LOAD follows the pads; every other state counts.
    if (state_q == ST_LOAD) begin
      count_d = pad_in_s;
    end else begin
      count_d = count_q + WIDTH'(1);
      if (count_q == '1) begin
        wrapped_d = 1'b1;
      end
    end

    // Any edge that lands in LOAD starts a fresh wrap history.
    if (state_d == ST_LOAD) begin
      wrapped_d = 1'b0;
    end

    // Snapshot the pre-increment count on each READ entry.
    if ((state_q != ST_READ) && (state_d == ST_READ)) begin
      snap_d = count_q;
    end

    // Drive the pads only once READ has been held for a full cycle, and
    // release them on the very edge that leaves READ.
    if ((state_q == ST_READ) && (state_d == ST_READ)) begin
      pad_oe_d  = 1'b1;
      pad_out_d = snap_d;
    end
  end

  // State register with synchronous active-low reset overriding everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      oeb_sync_q <= '1;
      web_sync_q <= '1;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        pad_sync_q[i] <= '0;
      end
      state_q   <= ST_IDLE;
      count_q   <= '0;
      wrapped_q <= 1'b0;
      snap_q    <= '0;
      pad_oe_q  <= 1'b0;
      pad_out_q <= '0;
    end else begin
      oeb_sync_q <= oeb_sync_d;
      web_sync_q <= web_sync_d;
      pad_sync_q <= pad_sync_d;
      state_q    <= state_d;
      count_q    <= count_d;
      wrapped_q  <= wrapped_d;
      snap_q     <= snap_d;
      pad_oe_q   <= pad_oe_d;
      pad_out_q  <= pad_out_d;
    end
  end

  assign count   = count_q;
  assign wrapped = wrapped_q;
  assign pad_oe  = {WIDTH{pad_oe_q}};
  assign pad_out = pad_out_q;

endmodule

`default_nettype wire
